// File: rtl/hbm_channel_arbiter.sv
// Arbitrates NUM_REQ requesters onto one HBM pseudo-channel and routes read data back in order.
// Optional starvation aging is built when HBM_ARB_AGING_EN is defined.
module hbm_channel_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 34,
    parameter int DATA_WIDTH      = 1024,
    parameter int MAX_OUTSTANDING = 8,
    parameter int AGE_LIMIT       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic [5:0]                          hbm_cmd,
    output logic [ADDR_WIDTH-1:0]               hbm_addr,
    output logic                                hbm_cmd_valid,
    input  logic                                hbm_cmd_ready,
    output logic [DATA_WIDTH-1:0]               hbm_wdata,
    output logic [DATA_WIDTH/8-1:0]             hbm_wstrb,
    output logic                                hbm_wvalid,
    input  logic                                hbm_wready,
    input  logic [DATA_WIDTH-1:0]               hbm_rdata,
    input  logic                                hbm_rvalid,
    output logic                                hbm_rready,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                spurious_rsp
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [5:0] CMD_RD = 6'b001101;
    localparam logic [5:0] CMD_WR = 6'b001100;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [5:0]           cmd_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]    wstrb_reg;
    logic [IDX_W-1:0]     cmd_id_reg;

    logic [IDX_W-1:0]     tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [NUM_REQ-1:0]   rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                 spurious_reg;

    logic                 read_ok;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_W-1:0]     scan_idx [NUM_REQ];
    logic                 rr_any, grant_any;
    logic [IDX_W-1:0]     rr_idx, grant_idx;
    logic                 grant_fire, push, pop;

    assign read_ok    = (count_reg < CNT_W'(MAX_OUTSTANDING));
    assign grant_fire = (state_reg == ST_IDLE) && grant_any;
    assign pop        = hbm_rvalid && (count_reg != '0);

    // scan_idx[k] is the requester visited k-th in the round-robin order starting at rr_ptr
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign eligible[gi]  = req_valid[gi] & (req_we[gi] | read_ok);
        assign scan_idx[gi]  = IDX_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
        assign req_ready[gi] = grant_fire && (grant_idx == IDX_W'(gi));
    end

    always_comb begin
        rr_any = 1'b0;
        rr_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[scan_idx[k]]) begin
                rr_any = 1'b1;
                rr_idx = scan_idx[k];
            end
        end
    end

`ifdef HBM_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0]   age_reg [NUM_REQ];
    logic [NUM_REQ-1:0] aged;
    logic               aged_any;
    logic [IDX_W-1:0]   aged_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
        assign aged[gi] = eligible[gi] && (age_reg[gi] >= AGE_W'(AGE_LIMIT));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                age_reg[gi] <= '0;
            else if (req_ready[gi])
                age_reg[gi] <= '0;
            else if (req_valid[gi] && (age_reg[gi] != AGE_W'(AGE_LIMIT)))
                age_reg[gi] <= age_reg[gi] + 1'b1;
        end
    end

    always_comb begin
        aged_any = 1'b0;
        aged_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (aged[k]) begin
                aged_any = 1'b1;
                aged_idx = IDX_W'(k);
            end
        end
        grant_any = rr_any;
        grant_idx = aged_any ? aged_idx : rr_idx;
    end
`else
    assign grant_any = rr_any;
    assign grant_idx = rr_idx;
`endif

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        push        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    state_next  = ST_CMD;
                    rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            ST_CMD: begin
                if (hbm_cmd_ready) begin
                    if (cmd_reg == CMD_WR) begin
                        state_next = ST_WDATA;
                    end else begin
                        push       = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WDATA: begin
                if (hbm_wready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            cmd_reg    <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            cmd_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (grant_fire) begin
                cmd_reg    <= req_we[grant_idx] ? CMD_WR : CMD_RD;
                addr_reg   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_reg  <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                wstrb_reg  <= req_wstrb[grant_idx*STRB_W +: STRB_W];
                cmd_id_reg <= grant_idx;
            end
        end
    end

    // Tag storage carries no reset; only the pointers and count define validity
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_reg] <= cmd_id_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            spurious_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
            rsp_valid_reg <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr_reg]) : '0;
            if (pop)
                rsp_rdata_reg <= hbm_rdata;
            if (hbm_rvalid && (count_reg == '0))
                spurious_reg <= 1'b1;
        end
    end

    assign hbm_cmd       = cmd_reg;
    assign hbm_addr      = addr_reg;
    assign hbm_cmd_valid = (state_reg == ST_CMD);
    assign hbm_wdata     = wdata_reg;
    assign hbm_wstrb     = wstrb_reg;
    assign hbm_wvalid    = (state_reg == ST_WDATA);
    assign hbm_rready    = 1'b1;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign outstanding   = count_reg;
    assign spurious_rsp  = spurious_reg;

endmodule

// File: doc/hbm_channel_arbiter.md
# hbm_channel_arbiter

Shares one HBM pseudo-channel between several memory requesters: the L3 refill/writeback port and the accelerator AXI bridges. It sits between those requesters and the `hbm_cmd`/`hbm_wdata`/`hbm_rdata` pins of one channel. The `memory_subsystem` instantiates one arbiter per channel. Reads are returned in order using a requester-ID tag FIFO.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters
- `ADDR_WIDTH`, 34, HBM address width
- `DATA_WIDTH`, 1024, HBM beat width
- `MAX_OUTSTANDING`, 8, read tag FIFO depth (power of 2)
- `AGE_LIMIT`, 16, starvation threshold in cycles (aging build only)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  request pending per requester
- `req_ready`  out  NUM_REQ  one-hot accept; handshake on `valid&ready`
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ×ADDR_WIDTH  address
- `req_wdata`  in  NUM_REQ×DATA_WIDTH  write data
- `req_wstrb`  in  NUM_REQ×DATA_WIDTH/8  byte enables
- `rsp_valid`  out  NUM_REQ  one-hot read-data strobe
- `rsp_rdata`  out  DATA_WIDTH  read data, shared by all requesters
- `hbm_cmd`  out  6  read = 6'b001101, write = 6'b001100
- `hbm_addr`  out  ADDR_WIDTH  command address
- `hbm_cmd_valid`  out  1  command valid
- `hbm_cmd_ready`  in  1  command accepted
- `hbm_wdata`  out  DATA_WIDTH  write data
- `hbm_wstrb`  out  DATA_WIDTH/8  write strobes
- `hbm_wvalid`  out  1  write data valid
- `hbm_wready`  in  1  write data accepted
- `hbm_rdata`  in  DATA_WIDTH  read data
- `hbm_rvalid`  in  1  read data valid
- `hbm_rready`  out  1  tied to 1
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
- `spurious_rsp`  out  1  sticky flag: `hbm_rvalid` arrived with the tag FIFO empty

## Operation
- The FSM has three states: IDLE, CMD and WDATA.
- **IDLE**: pick a requester round-robin, starting from `rr_ptr`.
  - A read is eligible only while `outstanding < MAX_OUTSTANDING`. Writes are always eligible.
  - `req_ready[g]` is asserted combinationally for the winner `g`.
  - The request fields are latched into command registers.
  - `rr_ptr` becomes `(g+1) mod NUM_REQ`.
  - The FSM goes to CMD.
- **CMD**: `hbm_cmd_valid`=1, with `hbm_cmd` and `hbm_addr` held stable. When `hbm_cmd_ready` is seen:
  - Read: push `g` into the tag FIFO and go to IDLE.
  - Write: go to WDATA.
- **WDATA**: `hbm_wvalid`=1, with `hbm_wdata`, `hbm_wstrb` and `hbm_addr` held. When `hbm_wready` is seen, go to IDLE.
- **Response path**: on `hbm_rvalid` with the FIFO non-empty:
  - Pop the head ID `h`.
  - Register `rsp_valid[h]`=1 and `rsp_rdata`=`hbm_rdata`.
- **Response with FIFO empty**: drop the data and set `spurious_rsp`.
- **Outstanding count**: `outstanding` = FIFO occupancy. A push and a pop in the same cycle leave it unchanged. FIFO pointers wrap modulo `MAX_OUTSTANDING`.
- A requester must hold its request fields stable while `req_valid`=1 and it is not yet accepted.

## Timing
- **Reset values**: all outputs 0 except `hbm_rready`=1. FSM=IDLE, `rr_ptr`=0, FIFO empty, age counters 0.
- **Accept to command**: accept in cycle T, `hbm_cmd_valid` from T+1.
- **Best-case throughput**: one read per 2 cycles; one write per 3 cycles.
- **Read return latency**: `hbm_rvalid` in cycle R gives `rsp_valid` in R+1, a single-cycle pulse.
- **Backpressure**: `hbm_cmd_ready` or `hbm_wready` held low stalls in CMD or WDATA indefinitely. No new grant is issued and `req_ready` stays 0.
- **Full FIFO**: at `outstanding == MAX_OUTSTANDING`, reads are masked in IDLE and writes still win.
- **Responses never stall**: responses are accepted in every state, including while a command is pending.
- **Reset mid-operation**:
  - An asynchronous reset aborts everything immediately.
  - In-flight tags are discarded.
  - Later stray `hbm_rvalid` beats set `spurious_rsp`.

## Configuration
- **`HBM_ARB_AGING_EN` defined**:
  - Each requester has a saturating age counter. It increments each cycle that `req_valid`=1 and the requester is not granted, and clears on grant.
  - Any requester with age ≥ `AGE_LIMIT` that is also eligible has priority over round-robin; the lowest index wins among aged requesters.
  - `rr_ptr` still advances past the winner.
- **Undefined**: pure round-robin; no age counters are synthesized.

## Test plan
- **Single read**: req0 read of 0x1000, `hbm_cmd_ready`=1, HBM returns data 2 cycles later.
  - `hbm_cmd`=6'b001101 and `hbm_addr`=0x1000.
  - `rsp_valid[0]` pulses once with the matching data.
  - `outstanding` goes 0→1→0.
- **Round-robin fairness**: all 4 requesters issue reads continuously. The grant order is 0,1,2,3,0 and each `req_ready` is one-hot.
- **Write with backpressure**: req2 writes 0xDEADBEEF… to 0x3000 while `hbm_wready` is held low for 5 cycles.
  - `hbm_wvalid`, `hbm_wdata` and `hbm_addr` stay stable throughout.
  - The FSM returns to IDLE the cycle after `hbm_wready` rises.
- **Outstanding limit**:
  - Issue 8 reads with no returns. The 9th read is not granted, while a concurrent write is granted.
  - After one `hbm_rvalid`, the 9th read is accepted.
  - Returns arrive in order to requesters 0,1,2,3,0,….
- **Spurious response and reset**:
  - Reset in CMD with 3 tags outstanding: all outputs return to their reset values at once.
  - A subsequent `hbm_rvalid` sets `spurious_rsp` and produces no `rsp_valid`.
- **Aging** (`HBM_ARB_AGING_EN`): req3 is held waiting for `AGE_LIMIT` cycles behind higher-priority traffic. It wins at the next IDLE regardless of `rr_ptr`.
